// File: rtl/module_led_sequencer.sv
// LED pattern sequencer: prescaled or manual stepping through up, down, Gray-up
// and bounce patterns, with registered LED output, step tick and wrap pulses.
module module_led_sequencer #(
    parameter int TICK_COUNT = 13500000,
    parameter int WIDTH      = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] led_o,
    output logic             tick_o,
    output logic             wrap_o
);

    localparam int PRE_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int POS_W = $clog2(WIDTH);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_COUNT - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_GRAY   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    logic [PRE_W-1:0] pre;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [POS_W-1:0] pos, pos_nxt;
    logic             dir, dir_nxt;
    mode_t            mode_r;
    logic             adv_q, wrap_q;
    logic             terminal, adv, mode_chg, wrap_nxt;
    logic [WIDTH-1:0] pattern, led_nxt;

    assign terminal = (pre == PRE_LAST);
    assign adv      = en_i ? terminal : step_i;
    assign mode_chg = (mode_i != mode_r);

    // Next pattern state and whether this step closes a full period.
    always_comb begin
        cnt_nxt  = cnt;
        pos_nxt  = pos;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
        case (mode_r)
            MODE_UP, MODE_GRAY: begin
                cnt_nxt  = cnt + WIDTH'(1);
                wrap_nxt = &cnt;
            end
            MODE_DOWN: begin
                cnt_nxt  = cnt - WIDTH'(1);
                wrap_nxt = ~|cnt;
            end
            MODE_BOUNCE: begin
                if (!dir) begin
                    pos_nxt = pos + POS_W'(1);
                    if (pos_nxt == POS_LAST) dir_nxt = 1'b1;
                end else begin
                    pos_nxt = pos - POS_W'(1);
                    if (pos_nxt == '0) begin
                        dir_nxt  = 1'b0;
                        wrap_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pattern = cnt;
        case (mode_r)
            MODE_GRAY:   pattern = cnt ^ (cnt >> 1);
            MODE_BOUNCE: pattern = WIDTH'(1) << pos;
            default:     pattern = cnt;
        endcase
        led_nxt = ACTIVE_LOW ? ~pattern : pattern;
    end

    // adv_q/wrap_q stage the step so tick/wrap line up with the led_o change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre    <= '0;
            cnt    <= '0;
            pos    <= '0;
            dir    <= 1'b0;
            mode_r <= MODE_UP;
            adv_q  <= 1'b0;
            wrap_q <= 1'b0;
            led_o  <= {WIDTH{ACTIVE_LOW}};
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            led_o  <= led_nxt;
            tick_o <= adv_q;
            wrap_o <= wrap_q;
            if (mode_chg) begin
                mode_r <= mode_t'(mode_i);
                pre    <= '0;
                cnt    <= '0;
                pos    <= '0;
                dir    <= 1'b0;
                adv_q  <= 1'b0;
                wrap_q <= 1'b0;
            end else begin
                if (en_i) pre <= terminal ? '0 : pre + PRE_W'(1);
                adv_q  <= adv;
                wrap_q <= adv & wrap_nxt;
                if (adv) begin
                    cnt <= cnt_nxt;
                    pos <= pos_nxt;
                    dir <= dir_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_module_led_sequencer.sv
// Directed bench for module_led_sequencer (WIDTH=4, TICK_COUNT=3), with a second
// active-low instance sharing the same stimulus.
module tb_module_led_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_i;
    logic [1:0] mode_i;
    logic       step_i;
    logic [3:0] led, led_al;
    logic       tick, wrap, tick_al, wrap_al;

    int passed = 0;
    int total  = 0;

    logic [3:0] gray_t [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] bounce_t [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};

    module_led_sequencer #(.TICK_COUNT(3), .WIDTH(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .step_i(step_i),
        .led_o(led), .tick_o(tick), .wrap_o(wrap)
    );

    module_led_sequencer #(.TICK_COUNT(3), .WIDTH(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en_i(en_i), .mode_i(mode_i), .step_i(step_i),
        .led_o(led_al), .tick_o(tick_al), .wrap_o(wrap_al)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_pat(input int mode, input int k);
        case (mode)
            2:       return gray_t[k % 16];
            3:       return bounce_t[k % 6];
            default: return 4'(k % 16);
        endcase
    endfunction

    // Mode was just changed (or reset released into it): edge r=1 loads the mode,
    // the new pattern shows from r=2, and steps land on edges 4,7,10,...
    task automatic run_pattern(input int mode, input int last_r);
        int k, period;
        logic tk, wr;
        logic [3:0] e, e_al;
        period = (mode == 3) ? 6 : 16;
        for (int r = 1; r <= last_r; r++) begin
            cyc();
            if (r >= 2) begin
                k    = (r - 2) / 3;
                tk   = (r >= 5) && ((r - 2) % 3 == 0);
                wr   = tk && (k % period == 0);
                e    = exp_pat(mode, k);
                e_al = ~e;
                check("pat_led", {4'h0, led}, {4'h0, e});
                check("pat_tick", {7'h0, tick}, {7'h0, tk});
                check("pat_wrap", {7'h0, wrap}, {7'h0, wr});
                check("pat_led_al", {4'h0, led_al}, {4'h0, e_al});
            end
        end
    endtask

    initial begin
        int wraps;
        int k;
        logic tk;
        logic [3:0] e, e_al;

        rst = 1'b0; en_i = 1'b1; mode_i = 2'b00; step_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", {4'h0, led}, 8'h00);
        check("rst_tick", {7'h0, tick}, 8'h00);
        check("rst_wrap", {7'h0, wrap}, 8'h00);
        check("rst_led_al", {4'h0, led_al}, 8'h0F);

        // Up mode straight out of reset: steps on edges 3,6,9,...
        rst = 1'b1;
        wraps = 0;
        for (int n = 1; n <= 76; n++) begin
            cyc();
            k    = (n - 1) / 3;
            tk   = (n >= 4) && ((n - 1) % 3 == 0);
            e    = 4'(k % 16);
            e_al = ~e;
            check("up_led", {4'h0, led}, {4'h0, e});
            check("up_tick", {7'h0, tick}, {7'h0, tk});
            check("up_wrap", {7'h0, wrap}, {7'h0, tk && (e == 4'h0)});
            check("up_led_al", {4'h0, led_al}, {4'h0, e_al});
            if (wrap) wraps++;
        end
        check("up_wrap_count", 8'(wraps), 8'd1);
        check("up_at_9", {4'h0, led}, 8'h09);

        // Asynchronous reset between edges while tick is high.
        #3;
        rst = 1'b0;
        #1;
        check("arst_led", {4'h0, led}, 8'h00);
        check("arst_tick", {7'h0, tick}, 8'h00);
        check("arst_wrap", {7'h0, wrap}, 8'h00);
        check("arst_led_al", {4'h0, led_al}, 8'h0F);

        @(posedge clk);
        #1;
        mode_i = 2'b10;
        rst = 1'b1;
        run_pattern(2, 52);

        mode_i = 2'b11;
        run_pattern(3, 41);

        mode_i = 2'b00;
        run_pattern(0, 11);
        check("pre_pause_led", {4'h0, led}, 8'h03);

        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("pause_led", {4'h0, led}, 8'h03);
            check("pause_tick", {7'h0, tick}, 8'h00);
        end
        for (int i = 1; i <= 3; i++) begin
            step_i = 1'b1;
            cyc();
            check("step_tick_lo", {7'h0, tick}, 8'h00);
            step_i = 1'b0;
            cyc();
            check("step_led", {4'h0, led}, 8'(3 + i));
            check("step_tick", {7'h0, tick}, 8'h01);
            check("step_wrap", {7'h0, wrap}, 8'h00);
        end

        // Resume from held prescaler (1): two cycles to terminal; step_i ignored.
        en_i = 1'b1;
        step_i = 1'b1;
        cyc();
        check("resume_led0", {4'h0, led}, 8'h06);
        check("resume_tick0", {7'h0, tick}, 8'h00);
        cyc();
        check("resume_tick1", {7'h0, tick}, 8'h00);
        cyc();
        check("resume_led2", {4'h0, led}, 8'h07);
        check("resume_tick2", {7'h0, tick}, 8'h01);
        cyc();
        check("resume_tick3", {7'h0, tick}, 8'h00);
        cyc();
        check("resume_led4", {4'h0, led}, 8'h07);
        check("resume_tick4", {7'h0, tick}, 8'h00);
        cyc();
        check("resume_led5", {4'h0, led}, 8'h08);
        check("resume_tick5", {7'h0, tick}, 8'h01);
        step_i = 1'b0;

        // Up->down at cnt=5, landing on the terminal-count edge.
        rst = 1'b0;
        mode_i = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (17) cyc();
        check("mc_pre_led", {4'h0, led}, 8'h05);
        mode_i = 2'b01;
        cyc();
        check("mc_edge_led", {4'h0, led}, 8'h05);
        check("mc_edge_tick", {7'h0, tick}, 8'h00);
        cyc();
        check("mc_led0", {4'h0, led}, 8'h00);
        check("mc_tick0", {7'h0, tick}, 8'h00);
        check("mc_wrap0", {7'h0, wrap}, 8'h00);
        cyc();
        check("mc_tick1", {7'h0, tick}, 8'h00);
        cyc();
        check("mc_led2", {4'h0, led}, 8'h00);
        check("mc_tick2", {7'h0, tick}, 8'h00);
        cyc();
        check("mc_led3", {4'h0, led}, 8'h0F);
        check("mc_tick3", {7'h0, tick}, 8'h01);
        check("mc_wrap3", {7'h0, wrap}, 8'h01);
        check("mc_led3_al", {4'h0, led_al}, 8'h00);
        cyc();
        check("mc_tick4", {7'h0, tick}, 8'h00);
        check("mc_wrap4", {7'h0, wrap}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/module_led_sequencer.md
# module_led_sequencer

Parametrised LED pattern sequencer that replaces the fixed 6-bit free-running LED counter on the board-bring-up path. A shared prescaler divides `clk` down to a step rate. The block then walks an internal state through one of four selectable patterns: binary up, binary down, Gray up, or bounce (one-hot walking light). It supports run/pause, manual single-step and selectable output polarity, and reports step and wrap events to status logic.

## Interface
- `TICK_COUNT`, 13500000: `clk` cycles per automatic step; legal range ≥1.
- `WIDTH`, 6: LED count; legal range ≥2.
- `ACTIVE_LOW`, 1: 1 = `led_o` inverted for active-low LEDs; 0 = true polarity.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  1 = prescaler runs (auto-step); 0 = pause, manual stepping allowed.
- `mode_i`  in  2  00 up, 01 down, 10 Gray up, 11 bounce.
- `step_i`  in  1  manual advance; acted on per cycle while `en_i`=0.
- `led_o`  out  WIDTH  registered pattern after polarity.
- `tick_o`  out  1  one-cycle pulse; aligned with each `led_o` change caused by a step.
- `wrap_o`  out  1  one-cycle pulse; aligned with the step that completes a pattern period.

## Operation
- Prescaler `pre`: width max(1, $clog2(TICK_COUNT)); counts 0..TICK_COUNT-1. Terminal = (`pre`==TICK_COUNT-1).
  - When `en_i`=1: `pre` increments; at terminal it returns to 0.
  - When `en_i`=0: `pre` holds its value. It does not clear.
- Advance event `adv` = (`en_i` & terminal) | (!`en_i` & `step_i`). `step_i` is ignored while `en_i`=1. A `step_i` held high for N cycles gives N advances.
- State: `cnt` [WIDTH], `pos` [$clog2(WIDTH)], `dir` (0 = left), `mode_r` [2].
- On `adv`, per `mode_r`:
  - up and Gray: `cnt`+1, mod 2^WIDTH.
  - down: `cnt`-1, mod 2^WIDTH.
  - bounce: `pos`±1. `dir` flips on reaching WIDTH-1 (flip to right) and on reaching 0 (flip to left).
- Wrap condition:
  - up/Gray: `cnt` goes 2^WIDTH-1→0.
  - down: `cnt` goes 0→2^WIDTH-1.
  - bounce: `pos` goes 1→0. Period is 2·(WIDTH-1) steps.
- Pattern, by mode: up/down = `cnt`; Gray = `cnt` ^ (`cnt`>>1); bounce = 1<<`pos`.
- `led_o` = ACTIVE_LOW ? ~pattern : pattern.
- Mode change: when `mode_i` ≠ `mode_r`, the next edge does the following:
  - loads `mode_r`;
  - clears `cnt`, `pos`, `dir` and `pre`;
  - discards any coincident `adv`: no `tick_o`, no `wrap_o`.
- `mode_i` is assumed glitch-free at `clk` level; no synchronizer is inside this block.

## Timing
- Reset (async, immediate, independent of `clk`):
  - `pre`=0, `cnt`=0, `pos`=0, `dir`=0, `mode_r`=00;
  - `tick_o`=0, `wrap_o`=0;
  - `led_o` = all-ones if ACTIVE_LOW, else 0.
- After reset release, if `mode_i`≠00 the mode-change rule applies on the first edge.
- A reset asserted mid-period discards the partial prescaler count.
- Latency: `adv` at edge E updates state at E. `led_o`, `tick_o` and `wrap_o` update together at E+1 (registered outputs, 1-cycle latency).
- Auto rate: with `en_i` held at 1, exactly one `tick_o` every TICK_COUNT cycles. TICK_COUNT=1 gives `tick_o` every cycle.
- Pause/resume: `en_i` 1→0→1 resumes from the held `pre`. The total cycle count between ticks equals TICK_COUNT plus the paused cycles.
- Mode change: the initial pattern of the new mode appears on `led_o` one cycle after `mode_r` loads.
  - up/down/Gray start at 0; bounce starts at bit0.
  - The first automatic step comes TICK_COUNT enabled cycles after the change.
- Down mode's first step from 0 produces 2^WIDTH-1 with `wrap_o`=1.

## Test plan
Bench parameters: WIDTH=4, TICK_COUNT=3, ACTIVE_LOW=0, unless stated.

- Reset: drop `rst` mid-cycle at count 9 → `led_o`=0, `tick_o`=0, `wrap_o`=0 immediately, with no clock edge. With ACTIVE_LOW=1, `led_o`=4'hF.
- Up mode, `en_i`=1 → `tick_o` every 3 cycles. `led_o` runs 0,1,…,15,0. `wrap_o` is high only with the 15→0 change, i.e. once per 48 cycles.
- Gray mode → `led_o` runs 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, …, 1000, 0000. Exactly one bit changes per tick. `wrap_o` fires on the return to 0000.
- Bounce mode → `led_o` runs 0001, 0010, 0100, 1000, 0100, 0010, 0001. `wrap_o` fires only at the return to 0001, giving a 6-tick period.
- Pause and step:
  - `en_i`=0 for 10 cycles → `led_o` and `pre` frozen, no `tick_o`.
  - 3 `step_i` pulses → `led_o` +3, one `tick_o` each.
  - `en_i`=1 → the first tick comes after the remaining prescaler cycles. `step_i` is ignored while `en_i`=1.
- Mode change: switch up→down at `cnt`=5 on the same cycle as the terminal count → `led_o`=0 next cycle, with no `tick_o` and no `wrap_o`. Three cycles later `led_o`=15, with `tick_o`=1 and `wrap_o`=1.
